// File: rtl/ula_pkg.sv
// Shared definitions for the 4-bit ALU: datapath width and the multiplier FSM encoding.
package ula_pkg;

    localparam int ULA_LARGURA = 4;

    // Index of the last shift-and-add iteration (four iterations: 0..3).
    localparam logic [1:0] CNT_ULTIMO = 2'd3;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        CALC   = 2'd1,
        FIM    = 2'd2
    } estado_t;

endpackage

// File: rtl/somadorde4bits.sv
// 4-bit ripple-carry adder shared by the ALU; the multiplier drives it with ACC + M.
module somadorde4bits
    import ula_pkg::*;
(
    input  logic [ULA_LARGURA-1:0] A,
    input  logic [ULA_LARGURA-1:0] B,
    input  logic                   Crry,
    output logic [ULA_LARGURA-1:0] S,
    output logic                   Cout
);

    always_comb begin : ripple
        logic carry;
        carry = Crry;
        S     = '0;
        for (int i = 0; i < ULA_LARGURA; i++) begin
            S[i]  = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        Cout = carry;
    end

endmodule

// File: rtl/multiplicador4bits.sv
// Sequential 4x4 unsigned shift-and-add multiplier built around somadorde4bits.
// Start is accepted in OCIOSO; four CALC iterations follow, then one FIM cycle with done.
module multiplicador4bits
    import ula_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ULA_LARGURA-1:0]   A,
    input  logic [ULA_LARGURA-1:0]   B,
    output logic [2*ULA_LARGURA-1:0] P,
    output logic                     busy,
    output logic                     done
);

    estado_t                  estado_q;
    logic [ULA_LARGURA-1:0]   m_q;
    logic [ULA_LARGURA-1:0]   q_q,   q_d;
    logic [ULA_LARGURA-1:0]   acc_q, acc_d;
    logic [1:0]               cnt_q;
    logic [2*ULA_LARGURA-1:0] p_q;

    logic [ULA_LARGURA-1:0]   soma_s;
    logic                     soma_c;
    logic [ULA_LARGURA:0]     parcial;

    somadorde4bits soma (
        .A    (acc_q),
        .B    (m_q),
        .Crry (1'b0),
        .S    (soma_s),
        .Cout (soma_c)
    );

    // Select the partial sum on Q[0], then shift {C,S,Q} right by one.
    // NOTE: every always_comb output gets a value before any branch, so no latch is inferred.
    always_comb begin
        parcial = {1'b0, acc_q};
        if (q_q[0]) begin
            parcial = {soma_c, soma_s};
        end
        acc_d = parcial[ULA_LARGURA:1];
        q_d   = {parcial[0], q_q[ULA_LARGURA-1:1]};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    // NOTE: every register is cleared by reset, so a mid-operation reset leaves no stale operand behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= OCIOSO;
            m_q      <= '0;
            q_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (start) begin
                        m_q      <= A;
                        q_q      <= B;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        estado_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == CNT_ULTIMO) begin
                        p_q      <= {acc_d, q_d};
                        estado_q <= FIM;
                    end
                end
                FIM: begin
                    estado_q <= OCIOSO;
                end
                default: begin
                    estado_q <= OCIOSO;
                end
            endcase
        end
    end

    assign P    = p_q;
    assign busy = (estado_q == CALC) || (estado_q == FIM);
    assign done = (estado_q == FIM);

endmodule
